// File: rtl/bfly_pkg.sv
// Shared butterfly-network definitions: packet layout, lane count, FSM state type.
// BUTTERFLY_INJECTOR_PARITY_EN narrows seq to 2 bits and adds an even-parity bit at [32].
package bfly_pkg;

    localparam int unsigned LANES    = 16;
    localparam int unsigned DEST_W   = $clog2(LANES);
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PKT_W    = 40;
    localparam int unsigned MSG_W    = DEST_W + DATA_W;

    localparam int unsigned VALID_BIT = 39;
    localparam int unsigned DEST_LSB  = 35;
    localparam int unsigned SEQ_MSB   = 34;

`ifdef BUTTERFLY_INJECTOR_PARITY_EN
    localparam int unsigned SEQ_W   = 2;
    localparam int unsigned PAR_BIT = 32;
`else
    localparam int unsigned SEQ_W   = 3;
`endif
    localparam int unsigned SEQ_LSB = SEQ_MSB - SEQ_W + 1;

    typedef enum logic [0:0] {
        ST_EMPTY   = 1'b0,
        ST_PRESENT = 1'b1
    } bfly_state_e;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } bfly_msg_t;

    function automatic logic [PKT_W-1:0] make_pkt(input bfly_msg_t msg,
                                                  input logic [SEQ_W-1:0] seq);
        logic [PKT_W-1:0] pkt;
        pkt                        = '0;
        pkt[VALID_BIT]             = 1'b1;
        pkt[DEST_LSB +: DEST_W]    = msg.dest;
        pkt[SEQ_LSB +: SEQ_W]      = seq;
        pkt[DATA_W-1:0]            = msg.data;
`ifdef BUTTERFLY_INJECTOR_PARITY_EN
        // Even parity over dest/seq and payload; the valid bit is excluded.
        pkt[PAR_BIT] = ^{pkt[VALID_BIT-1:SEQ_LSB], pkt[DATA_W-1:0]};
`endif
        return pkt;
    endfunction

endpackage

// File: rtl/bfly_fifo.sv
// Circular message FIFO for the injector; power-of-two DEPTH, synchronous flush.
module bfly_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign level   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/butterfly_injector.sv
// Butterfly network injector: queues messages and presents one stamped packet per lane slot.
// Optional parity format selected by BUTTERFLY_INJECTOR_PARITY_EN (see bfly_pkg).
module butterfly_injector
    import bfly_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter logic [3:0]  SRC_ID = 4'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DEST_W-1:0]      in_dest,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   grant_i,
    input  logic                   flush_i,
    output logic [PKT_W-1:0]       pkt_o,
    output logic [3:0]             src_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [15:0]            launch_cnt
);

    bfly_state_e      state_q, state_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             fifo_full, fifo_empty;
    logic             accept, launch, load;
    bfly_msg_t        in_msg, head_msg;
    logic [MSG_W-1:0] head_raw;

    assign in_msg   = '{dest: in_dest, data: in_data};
    assign head_msg = bfly_msg_t'(head_raw);

    assign in_ready = !fifo_full && !flush_i;
    assign accept   = in_valid && in_ready;
    assign launch   = (state_q == ST_PRESENT) && grant_i && !flush_i;
    // A new packet enters the slot when it is free or being vacated by a launch.
    assign load     = !fifo_empty && !flush_i && ((state_q == ST_EMPTY) || launch);

    bfly_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MSG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (accept),
        .wdata (in_msg),
        .pop   (load),
        .rdata (head_raw),
        .level (level_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            pkt_d   = '0;
        end else begin
            if (launch && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
            if (load) begin
                state_d = ST_PRESENT;
                pkt_d   = make_pkt(head_msg, seq_q);
                seq_d   = seq_q + 1'b1;
            end else if (launch) begin
                state_d = ST_EMPTY;
                pkt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            pkt_q   <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pkt_o      = pkt_q;
    assign src_o      = SRC_ID;
    assign launch_cnt = cnt_q;

endmodule
